maxpool_seq: RTL

MAXPOOL_SEQ -- requirements
Module: maxpool_seq

---
 rtl/maxpool_seq_pkg.sv | 39 +++
 rtl/maxpool_seq_addr_gen.sv | 50 +++++
 rtl/maxpool_seq.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/maxpool_seq_pkg.sv
// ---------------------------------------------------------------------------
// maxpool_seq_pkg
// Shared definitions for the max-pool sequencer:
//   - sequencer state encoding
//   - default widths and the largest legal map dimension
//   - job configuration legality check
// ---------------------------------------------------------------------------
package maxpool_seq_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int ADDR_WIDTH_DEF = 20;
    localparam int MAX_CH_DEF     = 256;

    // Per-channel counters must hold 416*416 = 173056 pixels.
    localparam int CNT_W = 18;

    localparam logic [8:0] MAX_MAP_DIM = 9'd416;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CHECK   = 3'd1,
        S_LAUNCH  = 3'd2,
        S_STREAM  = 3'd3,
        S_WAIT    = 3'd4,
        S_NEXT_CH = 3'd5
    } state_t;

    // Width/height must be even and in 2..MAX_MAP_DIM; channels in 1..max_ch.
    function automatic logic cfg_ok(input logic [8:0] w,
                                    input logic [8:0] h,
                                    input logic [8:0] ch,
                                    input logic [8:0] max_ch);
        return !w[0] && !h[0]
            && (w >= 9'd2) && (w <= MAX_MAP_DIM)
            && (h >= 9'd2) && (h <= MAX_MAP_DIM)
            && (ch != 9'd0) && (ch <= max_ch);
    endfunction

endpackage

// File: rtl/maxpool_seq_addr_gen.sv
// ---------------------------------------------------------------------------
// maxpool_addr_gen
// Address pointer plus per-channel event counter.
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_load/i_base : start of job; pointer <= base, count <= 0
//   i_clr         : restart the per-channel count (pointer keeps running)
//   i_inc         : one access this cycle; pointer and count advance
//   i_limit       : accesses expected per channel
//   o_ptr         : current address (wraps modulo 2^ADDR_WIDTH)
//   o_term        : count including this cycle's access equals i_limit
// ---------------------------------------------------------------------------
module maxpool_addr_gen #(
    parameter int ADDR_WIDTH = 20,
    parameter int CNT_WIDTH  = 18
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic [ADDR_WIDTH-1:0] i_base,
    input  logic                  i_clr,
    input  logic                  i_inc,
    input  logic [CNT_WIDTH-1:0]  i_limit,
    output logic [ADDR_WIDTH-1:0] o_ptr,
    output logic                  o_term
);

    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_inc;

    // Looking one access ahead lets the caller act on the cycle of the last
    // access instead of one cycle later.
    assign cnt_inc = cnt + CNT_WIDTH'(i_inc);
    assign o_term  = (cnt_inc == i_limit);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_ptr <= '0;
            cnt   <= '0;
        end else if (i_load) begin
            o_ptr <= i_base;
            cnt   <= '0;
        end else begin
            if (i_inc) begin
                o_ptr <= o_ptr + ADDR_WIDTH'(1);
            end
            cnt <= i_clr ? CNT_WIDTH'(i_inc) : cnt_inc;
        end
    end

endmodule

// File: rtl/maxpool_seq.sv
// ---------------------------------------------------------------------------
// maxpool_seq
// Sequences 2x2 max-pool jobs over a multi-channel feature map: streams each
// channel from source memory into the pooling engine and writes the engine's
// results contiguously to the destination map.
//
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_start                       one-cycle job request (IDLE only)
//   i_width, i_height, i_channels map geometry, latched on accepted start
//   i_src_base, i_dst_base        map base addresses, latched on start
//   o_rd_en, o_rd_addr, i_rd_data source read port (data one cycle later)
//   o_pool_start, o_pool_data     engine start pulse and pixel stream
//   i_pool_valid/data/done        engine results and channel completion
//   o_wr_en, o_wr_addr, o_wr_data destination write port (same-cycle pass)
//   o_busy, o_done, o_err         job active, completion pulse, error pulse
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for i_start
// S_CHECK   | validate latched config, precompute per-channel counts
// S_LAUNCH  | engine start pulse, first read of the channel
// S_STREAM  | one read per cycle until the channel is fully read
// S_WAIT    | wait for engine completion, verify write count
// S_NEXT_CH | finish job or advance to the next channel
// ---------------------------------------------------------------------------
module maxpool_seq
    import maxpool_seq_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int MAX_CH     = MAX_CH_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [8:0]            i_width,
    input  logic [8:0]            i_height,
    input  logic [8:0]            i_channels,
    input  logic [ADDR_WIDTH-1:0] i_src_base,
    input  logic [ADDR_WIDTH-1:0] i_dst_base,
    output logic                  o_rd_en,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic                  o_pool_start,
    output logic [DATA_WIDTH-1:0] o_pool_data,
    input  logic                  i_pool_valid,
    input  logic [DATA_WIDTH-1:0] i_pool_data,
    input  logic                  i_pool_done,
    output logic                  o_wr_en,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err
);

    localparam logic [8:0] MAX_CH_L = 9'(MAX_CH);

    state_t           state;
    logic [8:0]       width_q;
    logic [8:0]       height_q;
    logic [8:0]       chan_q;
    logic [8:0]       ch_q;
    logic [CNT_W-1:0] npix_q;
    logic [CNT_W-1:0] nwr_q;
    logic             rd_vld_q;

    logic                  accept;
    logic                  ch_clr;
    logic                  wr_en;
    logic                  src_term;
    logic                  dst_term;
    logic [ADDR_WIDTH-1:0] src_ptr;
    logic [ADDR_WIDTH-1:0] dst_ptr;

    assign accept = (state == S_IDLE) && i_start;
    assign ch_clr = (state == S_NEXT_CH);

    // Engine results are written in the cycle they arrive; nothing is
    // written outside a job or in a reset cycle.
    assign wr_en     = i_pool_valid && (state != S_IDLE) && !i_rst;
    assign o_wr_en   = wr_en;
    assign o_wr_addr = dst_ptr;
    assign o_wr_data = wr_en ? i_pool_data : '0;

    assign o_rd_addr = src_ptr;

    // Memory data lands one cycle after the read; rd_vld_q marks exactly
    // those cycles so the stream is zero everywhere else.
    assign o_pool_data = rd_vld_q ? i_rd_data : '0;

    maxpool_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .CNT_WIDTH  (CNT_W)
    ) u_src_gen (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (accept),
        .i_base  (i_src_base),
        .i_clr   (ch_clr),
        .i_inc   (o_rd_en),
        .i_limit (npix_q),
        .o_ptr   (src_ptr),
        .o_term  (src_term)
    );

    maxpool_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .CNT_WIDTH  (CNT_W)
    ) u_dst_gen (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (accept),
        .i_base  (i_dst_base),
        .i_clr   (ch_clr),
        .i_inc   (wr_en),
        .i_limit (nwr_q),
        .o_ptr   (dst_ptr),
        .o_term  (dst_term)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= S_IDLE;
            width_q      <= '0;
            height_q     <= '0;
            chan_q       <= '0;
            ch_q         <= '0;
            npix_q       <= '0;
            nwr_q        <= '0;
            rd_vld_q     <= 1'b0;
            o_rd_en      <= 1'b0;
            o_pool_start <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            o_pool_start <= 1'b0;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
            rd_vld_q     <= o_rd_en;

            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        width_q  <= i_width;
                        height_q <= i_height;
                        chan_q   <= i_channels;
                        o_busy   <= 1'b1;
                        state    <= S_CHECK;
                    end
                end

                S_CHECK: begin
                    npix_q <= CNT_W'(width_q) * CNT_W'(height_q);
                    nwr_q  <= CNT_W'(width_q[8:1]) * CNT_W'(height_q[8:1]);
                    ch_q   <= '0;
                    if (!cfg_ok(width_q, height_q, chan_q, MAX_CH_L)) begin
                        o_err  <= 1'b1;
                        o_busy <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        o_pool_start <= 1'b1;
                        o_rd_en      <= 1'b1;
                        state        <= S_LAUNCH;
                    end
                end

                // A channel has at least 4 pixels, so the launch read is
                // never the last one.
                S_LAUNCH: begin
                    state <= S_STREAM;
                end

                S_STREAM: begin
                    if (src_term) begin
                        o_rd_en <= 1'b0;
                        state   <= S_WAIT;
                    end
                end

                // dst_term already counts a write arriving with done.
                S_WAIT: begin
                    if (i_pool_done) begin
                        if (!dst_term) begin
                            o_err <= 1'b1;
                        end
                        state <= S_NEXT_CH;
                    end
                end

                S_NEXT_CH: begin
                    if (ch_q == chan_q - 9'd1) begin
                        o_done <= 1'b1;
                        o_busy <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        ch_q         <= ch_q + 9'd1;
                        o_pool_start <= 1'b1;
                        o_rd_en      <= 1'b1;
                        state        <= S_LAUNCH;
                    end
                end

                default: begin
                    o_rd_en <= 1'b0;
                    o_busy  <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
